// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ byte sources share one uart_tx input.
// A grant is held until a byte flagged last is sent, or until MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int MAX_BURST = 16,
  localparam int GW        = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               burst_cut
);

  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            cut_q, cut_d;

  logic [GW-1:0]   winner;
  logic [GW-1:0]   cand;
  logic            found;
  logic [7:0]      sel_data;
  logic            sel_valid;
  logic            sel_last;
  logic            burst_hit;

  // Search starts one past the previous grantee so every requester gets a turn.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = GW'((int'(ptr_q) + i) % N_REQ);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        sel_data     = req_data[8*i +: 8];
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        // Ready depends on registered state only, never on req_valid.
        req_ready[i] = (state_q == LOCKED) && !valid_q;
      end
    end
  end

  assign burst_hit = (MAX_BURST != 0) && (cnt_q == CW'(MAX_BURST));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    cut_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          cnt_d   = '0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (!valid_q) begin
          if (sel_valid) begin
            data_d  = sel_data;
            last_d  = sel_last;
            valid_d = 1'b1;
            if (MAX_BURST != 0) cnt_d = cnt_q + 1'b1;
          end
        end else if (tx_ready) begin
          // Dropping valid for a cycle gives uart_tx time to lower its ready.
          valid_d = 1'b0;
          if (last_q || burst_hit) begin
            ptr_d   = grant_q;
            state_d = IDLE;
            cut_d   = !last_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; all of them are reset because a
  // half-sent message must be discarded outright when reset hits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= GW'(N_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cut_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cut_q   <= cut_d;
    end
  end

  assign tx_data   = data_q;
  assign tx_valid  = valid_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q == LOCKED);
  assign burst_cut = cut_q;

endmodule
